// File: rtl/decode_pkg.sv
// Shared encodings for the decode control stage: field positions, opcodes,
// write-back selects, FSM states and the packed control bundle.
package decode_pkg;

  localparam int OPC_LO   = 27;
  localparam int OPC_W    = 5;
  localparam int RD_LO    = 22;
  localparam int RS_LO    = 17;
  localparam int RT_LO    = 12;
  localparam int ALUOP_LO = 2;
  localparam int ALUOP_W  = 5;
  localparam int IMM_W    = 17;
  localparam int TGT_W    = 27;

  localparam logic [OPC_W-1:0] OP_R    = 5'b00000;
  localparam logic [OPC_W-1:0] OP_J    = 5'b00001;
  localparam logic [OPC_W-1:0] OP_BNE  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_JR   = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OP_BLT  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SW   = 5'b00111;
  localparam logic [OPC_W-1:0] OP_LW   = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SETX = 5'b10101;
  localparam logic [OPC_W-1:0] OP_BEX  = 5'b10110;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 5'b00000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 5'b00001;
  localparam logic [ALUOP_W-1:0] ALU_MUL = 5'b00110;
  localparam logic [ALUOP_W-1:0] ALU_DIV = 5'b00111;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC1 = 2'b10;
  localparam logic [1:0] WB_MD  = 2'b11;

  localparam int REG_LINK = 31;
  localparam int REG_STAT = 30;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_MD_OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_sel;
    logic               imm_sel;
    logic               b_sel;
    logic               reg_we;
    logic               mem_we;
    logic [1:0]         wb_sel;
    logic               is_branch;
    logic               is_jump;
    logic               illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic is_md_aluop(input logic [ALUOP_W-1:0] a);
    return (a == ALU_MUL) || (a == ALU_DIV);
  endfunction

endpackage

// File: rtl/insn_decoder.sv
// Combinational opcode decoder: instruction word to raw control bundle,
// forced register addresses, extracted immediate/target and mul/div flags.
module insn_decoder
  import decode_pkg::*;
#(
  parameter int INSN_W     = 32,
  parameter int REG_AW     = 5,
  parameter bit MULTDIV_EN = 1'b1
) (
  input  logic [INSN_W-1:0] insn,
  output logic [CTRL_W-1:0] ctrl,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [31:0]       imm,
  output logic [TGT_W-1:0]  target,
  output logic              is_md,
  output logic              md_div
);

  logic [OPC_W-1:0]   opcode;
  logic [ALUOP_W-1:0] aluop;
  ctrl_t              c;

  assign opcode = insn[OPC_LO +: OPC_W];
  assign aluop  = insn[ALUOP_LO +: ALUOP_W];
  assign imm    = {{(32-IMM_W){insn[IMM_W-1]}}, insn[IMM_W-1:0]};
  assign target = insn[TGT_W-1:0];
  assign md_div = aluop[0];
  assign ctrl   = c;

  always_comb begin
    c     = '0;
    rd    = insn[RD_LO +: REG_AW];
    rs    = insn[RS_LO +: REG_AW];
    rt    = insn[RT_LO +: REG_AW];
    is_md = 1'b0;
    case (opcode)
      OP_R: begin
        c.alu_sel = aluop;
        c.reg_we  = 1'b1;
        c.wb_sel  = WB_ALU;
        if (is_md_aluop(aluop)) begin
          if (MULTDIV_EN) begin
            is_md = 1'b1;
          end else begin
            c.illegal = 1'b1;
            c.reg_we  = 1'b0;
          end
        end
      end
      OP_ADDI, OP_LW: begin
        c.alu_sel = ALU_ADD;
        c.b_sel   = 1'b1;
        c.imm_sel = 1'b1;
        c.reg_we  = 1'b1;
        c.wb_sel  = (opcode == OP_LW) ? WB_MEM : WB_ALU;
      end
      OP_SW: begin
        // store data is read through the rt port, so steer rd onto it
        c.b_sel   = 1'b1;
        c.imm_sel = 1'b1;
        c.mem_we  = 1'b1;
        rt        = insn[RD_LO +: REG_AW];
      end
      OP_BNE, OP_BLT: begin
        c.alu_sel   = ALU_SUB;
        c.is_branch = 1'b1;
      end
      OP_BEX: begin
        c.is_branch = 1'b1;
        rs          = REG_AW'(REG_STAT);
      end
      OP_J, OP_JR: c.is_jump = 1'b1;
      OP_JAL: begin
        c.is_jump = 1'b1;
        c.reg_we  = 1'b1;
        c.wb_sel  = WB_PC1;
        rd        = REG_AW'(REG_LINK);
      end
      OP_SETX: begin
        c.reg_we = 1'b1;
        rd       = REG_AW'(REG_STAT);
      end
      default: c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode stage: valid/ready handshake, held output bundle and a
// small FSM that sequences multi-cycle mult/div issue with a timeout.
module decode_ctrl_stage
  import decode_pkg::*;
#(
  parameter int INSN_W     = 32,
  parameter int REG_AW     = 5,
  parameter bit MULTDIV_EN = 1'b1,
  parameter int MD_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] insn,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        alu_sel,
  output logic              imm_sel,
  output logic              b_sel,
  output logic              reg_we,
  output logic              mem_we,
  output logic [1:0]        wb_sel,
  output logic              is_branch,
  output logic              is_jump,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [31:0]       imm,
  output logic [26:0]       target,
  output logic              illegal,
  output logic              md_start,
  output logic              md_is_div,
  input  logic              md_done,
  output logic              md_abort,
  output logic              md_err
);

  logic [CTRL_W-1:0] dec_ctrl;
  logic [REG_AW-1:0] dec_rd, dec_rs, dec_rt;
  logic [31:0]       dec_imm;
  logic [TGT_W-1:0]  dec_target;
  logic              dec_is_md, dec_md_div;

  insn_decoder #(
    .INSN_W     (INSN_W),
    .REG_AW     (REG_AW),
    .MULTDIV_EN (MULTDIV_EN)
  ) u_dec (
    .insn   (insn),
    .ctrl   (dec_ctrl),
    .rd     (dec_rd),
    .rs     (dec_rs),
    .rt     (dec_rt),
    .imm    (dec_imm),
    .target (dec_target),
    .is_md  (dec_is_md),
    .md_div (dec_md_div)
  );

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [REG_AW-1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
  logic [31:0]       imm_q, imm_d;
  logic [TGT_W-1:0]  target_q, target_d;
  logic              md_err_q, md_err_d;
  logic              in_ready_w, accept, md_start_w, md_abort_w;

  assign in_ready_w = !reset && !flush && (state_q == ST_IDLE) &&
                      (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready_w;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    imm_d       = imm_q;
    target_d    = target_q;
    md_err_d    = md_err_q;
    md_start_w  = 1'b0;
    md_abort_w  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((out_valid_q && out_ready) || flush) out_valid_d = 1'b0;
        if (accept) begin
          ctrl_d   = ctrl_t'(dec_ctrl);
          rd_d     = dec_rd;
          rs_d     = dec_rs;
          rt_d     = dec_rt;
          imm_d    = dec_imm;
          target_d = dec_target;
          md_err_d = 1'b0;
          if (dec_is_md) begin
            // bundle parks in the output register until the unit answers
            md_start_w  = 1'b1;
            out_valid_d = 1'b0;
            cnt_d       = '0;
            state_d     = ST_MD_BUSY;
          end else begin
            out_valid_d = 1'b1;
          end
        end
      end
      ST_MD_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (flush) begin
          md_abort_w = 1'b1;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end else if (md_done) begin
          ctrl_d.wb_sel = WB_MD;
          md_err_d      = 1'b0;
          out_valid_d   = 1'b1;
          state_d       = ST_MD_OUT;
        end else if (cnt_q == 8'(MD_TIMEOUT - 1)) begin
          md_err_d    = 1'b1;
          out_valid_d = 1'b1;
          state_d     = ST_MD_OUT;
        end
      end
      ST_MD_OUT: begin
        if (flush || out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      imm_q       <= '0;
      target_q    <= '0;
      md_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      rd_q        <= rd_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      imm_q       <= imm_d;
      target_q    <= target_d;
      md_err_q    <= md_err_d;
    end
  end

  assign in_ready  = in_ready_w;
  assign md_start  = md_start_w;
  assign md_is_div = md_start_w && dec_md_div;
  assign md_abort  = md_abort_w && !reset;
  assign out_valid = out_valid_q;
  assign alu_sel   = ctrl_q.alu_sel;
  assign imm_sel   = ctrl_q.imm_sel;
  assign b_sel     = ctrl_q.b_sel;
  assign reg_we    = ctrl_q.reg_we;
  assign mem_we    = ctrl_q.mem_we;
  assign wb_sel    = ctrl_q.wb_sel;
  assign is_branch = ctrl_q.is_branch;
  assign is_jump   = ctrl_q.is_jump;
  assign illegal   = ctrl_q.illegal;
  assign rd        = rd_q;
  assign rs        = rs_q;
  assign rt        = rt_q;
  assign imm       = imm_q;
  assign target    = target_q;
  assign md_err    = md_err_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage with a scoreboard of expected bundles.
module tb_decode_ctrl_stage;

  logic        clock = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, md_done = 1'b0;
  logic [31:0] insn = '0;
  logic        in_ready, out_valid, imm_sel, b_sel, reg_we, mem_we;
  logic        is_branch, is_jump, illegal, md_start, md_is_div, md_abort, md_err;
  logic [4:0]  alu_sel, rd, rs, rt;
  logic [1:0]  wb_sel;
  logic [31:0] imm;
  logic [26:0] target;

  decode_ctrl_stage #(.INSN_W(32), .REG_AW(5), .MULTDIV_EN(1'b1), .MD_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .insn(insn), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_sel(alu_sel), .imm_sel(imm_sel), .b_sel(b_sel), .reg_we(reg_we),
    .mem_we(mem_we), .wb_sel(wb_sel), .is_branch(is_branch), .is_jump(is_jump),
    .rd(rd), .rs(rs), .rt(rt), .imm(imm), .target(target), .illegal(illegal),
    .md_start(md_start), .md_is_div(md_is_div), .md_done(md_done),
    .md_abort(md_abort), .md_err(md_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  alu;
    logic        imm_sel, b_sel, reg_we, mem_we;
    logic [1:0]  wb;
    logic        br, jmp;
    logic [4:0]  rd, rs, rt;
    logic [31:0] imm;
    logic [26:0] tgt;
    logic        ill, err;
  } bundle_t;

  bundle_t q[$];
  int total = 0, passed = 0, consumed = 0, md_start_cnt = 0, md_abort_cnt = 0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  task automatic checkb(input string tag, input bundle_t obs, input bundle_t exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic bundle_t observed();
    bundle_t o;
    o = {alu_sel, imm_sel, b_sel, reg_we, mem_we, wb_sel, is_branch, is_jump,
         rd, rs, rt, imm, target, illegal, md_err};
    return o;
  endfunction

  // reference decode written from the opcode table, field by field
  function automatic bundle_t model(input logic [31:0] i);
    bundle_t    b  = '0;
    logic [4:0] op = i[31:27];
    b.rd  = i[26:22];
    b.rs  = i[21:17];
    b.rt  = i[16:12];
    b.imm = {{15{i[16]}}, i[16:0]};
    b.tgt = i[26:0];
    if (op == 5'b00000) begin b.alu = i[6:2]; b.reg_we = 1'b1; end
    else if (op == 5'b00101 || op == 5'b01000) begin
      b.imm_sel = 1'b1; b.b_sel = 1'b1; b.reg_we = 1'b1;
      if (op == 5'b01000) b.wb = 2'b01;
    end
    else if (op == 5'b00111) begin b.imm_sel = 1'b1; b.b_sel = 1'b1; b.mem_we = 1'b1; b.rt = i[26:22]; end
    else if (op == 5'b00010 || op == 5'b00110) begin b.alu = 5'd1; b.br = 1'b1; end
    else if (op == 5'b10110) begin b.br = 1'b1; b.rs = 5'd30; end
    else if (op == 5'b00001 || op == 5'b00100) b.jmp = 1'b1;
    else if (op == 5'b00011) begin b.jmp = 1'b1; b.rd = 5'd31; b.reg_we = 1'b1; b.wb = 2'b10; end
    else if (op == 5'b10101) begin b.rd = 5'd30; b.reg_we = 1'b1; end
    else b.ill = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] d, s, t, a);
    return {5'b00000, d, s, t, 5'b00000, a, 2'b00};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] op, d, s, input logic [16:0] im);
    return {op, d, s, im};
  endfunction

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) check1("unexpected_bundle", out_valid, 1'b0);
      else checkb("bundle", observed(), q.pop_front());
      consumed++;
    end
  end

  always @(posedge clock) begin
    if (md_start) md_start_cnt <= md_start_cnt + 1;
    if (md_abort) md_abort_cnt <= md_abort_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // offer i until accepted; e is queued only when push is set
  task automatic send(input logic [31:0] i, input bundle_t e, input bit push,
                      input logic exp_start, input logic exp_div);
    int n = 0;
    in_valid = 1'b1;
    insn     = i;
    #1;
    while (!in_ready && n < 40) begin tick(); #1; n++; end
    check1("accept", in_ready, 1'b1);
    check1("md_start_at_accept", md_start, exp_start);
    check1("md_is_div_at_accept", md_is_div, exp_div);
    if (push) q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0] tbl [11];
  logic [31:0] ia, ib, mul_i, div_i;
  bundle_t     e;
  int          c0;

  initial begin
    tbl[0]  = mk_i(5'b01000, 5'd4, 5'd5, 17'h1FFFC);
    tbl[1]  = mk_i(5'b00111, 5'd6, 5'd7, 17'h00008);
    tbl[2]  = mk_i(5'b00010, 5'd1, 5'd2, 17'h00003);
    tbl[3]  = mk_i(5'b00110, 5'd3, 5'd4, 17'h1FFFF);
    tbl[4]  = {5'b10110, 27'h0000123};
    tbl[5]  = {5'b10101, 27'h0000005};
    tbl[6]  = {5'b00001, 27'h7FFFFFF};
    tbl[7]  = mk_i(5'b00100, 5'd9, 5'd0, 17'h0);
    tbl[8]  = mk_r(5'd10, 5'd11, 5'd12, 5'b00000);
    tbl[9]  = mk_r(5'd1, 5'd2, 5'd3, 5'b00001);
    tbl[10] = mk_i(5'b01111, 5'd8, 5'd9, 17'h00011);
    mul_i   = mk_r(5'd3, 5'd4, 5'd5, 5'b00110);
    div_i   = mk_r(5'd6, 5'd7, 5'd8, 5'b00111);

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_md_start", md_start, 1'b0);
    check1("rst_md_abort", md_abort, 1'b0);
    checkb("rst_bundle", observed(), '0);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    #1 check1("post_rst_in_ready", in_ready, 1'b1);

    // addi: one-cycle latency
    send(32'h2884000A, model(32'h2884000A), 1, 1'b0, 1'b0);
    #1 check1("addi_latency", out_valid, 1'b1);
    send({5'b00011, 27'h100}, model({5'b00011, 27'h100}), 1, 1'b0, 1'b0);
    send({5'b11111, 27'h0AB}, model({5'b11111, 27'h0AB}), 1, 1'b0, 1'b0);
    for (int k = 0; k < 11; k++) send(tbl[k], model(tbl[k]), 1, 1'b0, 1'b0);
    tick();

    // mul completes 5 cycles after accept
    c0 = md_start_cnt;
    e = model(mul_i); e.wb = 2'b11;
    send(mul_i, e, 1, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      #1 check1("mul_busy_in_ready", in_ready, 1'b0);
      check1("mul_busy_out_valid", out_valid, 1'b0);
      check1("mul_busy_md_start", md_start, 1'b0);
      tick();
    end
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    #1 check1("mul_out_valid", out_valid, 1'b1);
    check1("mul_in_ready_md_out", in_ready, 1'b0);
    check1("mul_md_start_once", (md_start_cnt - c0) == 1, 1'b1);
    tick(); tick();

    // div timeout at MD_TIMEOUT=8
    e = model(div_i); e.err = 1'b1;
    send(div_i, e, 1, 1'b1, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      #1 check1("div_wait_out_valid", out_valid, 1'b0);
    end
    tick();
    #1 check1("div_timeout_out_valid", out_valid, 1'b1);
    check1("div_timeout_md_err", md_err, 1'b1);
    tick(); tick();

    // md_done coinciding with the timeout cycle wins
    e = model(div_i); e.wb = 2'b11;
    send(div_i, e, 1, 1'b1, 1'b1);
    repeat (7) tick();
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    #1 check1("tie_md_err", md_err, 1'b0);
    check1("tie_out_valid", out_valid, 1'b1);
    tick(); tick();

    // flush 3 cycles into MD_BUSY
    c0 = md_abort_cnt;
    send(mul_i, e, 0, 1'b1, 1'b0);
    tick(); tick();
    flush = 1'b1;
    #1 check1("flush_md_abort", md_abort, 1'b1);
    tick();
    flush = 1'b0;
    #1 check1("flush_abort_pulse_gone", md_abort, 1'b0);
    check1("flush_out_valid", out_valid, 1'b0);
    check1("flush_idle_in_ready", in_ready, 1'b1);
    check1("flush_abort_once", (md_abort_cnt - c0) == 1, 1'b1);
    send(tbl[8], model(tbl[8]), 1, 1'b0, 1'b0);
    tick();

    // backpressure with two queued instructions
    ia = tbl[0]; ib = tbl[5];
    out_ready = 1'b0;
    c0 = consumed;
    send(ia, model(ia), 1, 1'b0, 1'b0);
    in_valid = 1'b1; insn = ib;
    q.push_back(model(ib));
    for (int k = 0; k < 4; k++) begin
      #1 check1("bp_in_ready", in_ready, 1'b0);
      checkb("bp_hold", observed(), model(ia));
      tick();
    end
    out_ready = 1'b1;
    #1 check1("bp_release_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    #1 checkb("bp_second", observed(), model(ib));
    tick();
    #1 check1("bp_no_loss_dup", (consumed - c0) == 2, 1'b1);

    // flush in MD_OUT drops the bundle without abort
    out_ready = 1'b0;
    c0 = md_abort_cnt;
    send(mul_i, e, 0, 1'b1, 1'b0);
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    #1 check1("mdout_valid", out_valid, 1'b1);
    flush = 1'b1;
    #1 check1("mdout_flush_no_abort", md_abort, 1'b0);
    tick();
    flush = 1'b0;
    #1 check1("mdout_flush_drop", out_valid, 1'b0);
    check1("mdout_abort_cnt", (md_abort_cnt - c0) == 0, 1'b1);
    out_ready = 1'b1;

    // flush together with in_valid: not accepted
    c0 = consumed;
    in_valid = 1'b1; insn = tbl[9]; flush = 1'b1;
    #1 check1("flush_blocks_accept", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1 check1("flush_no_bundle", out_valid, 1'b0);

    // md_done in IDLE is ignored
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    #1 check1("idle_md_done_valid", out_valid, 1'b0);
    check1("idle_md_done_ready", in_ready, 1'b1);

    // reset during MD_BUSY gives no abort even with flush high
    send(div_i, e, 0, 1'b1, 1'b1);
    tick();
    reset = 1'b1; flush = 1'b1;
    #1 check1("rst_busy_no_abort", md_abort, 1'b0);
    tick();
    reset = 1'b0; flush = 1'b0;
    #1 check1("rst_busy_idle", in_ready, 1'b1);
    check1("rst_busy_out_valid", out_valid, 1'b0);

    tick(); tick();
    check1("scoreboard_empty", q.size() == 0, 1'b1);
    check1("flush_nothing_consumed", (consumed - c0) == 0, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
